// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: bus field widths, ACK level, FSM states.
package i2c_target_pkg;

    localparam int         ADDR_W   = 7;     // 7-bit device address
    localparam int         SUB_W    = 8;     // sub-address / data byte width
    localparam logic       ACK      = 1'b0;  // bus level of an acknowledge
    localparam logic [3:0] ACK_SLOT = 4'd8;  // bit_cnt value of the ninth clock

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_SUB,
        ST_ACK_S,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_P
    } tgt_state_e;

endpackage

// File: rtl/i2c_target_if.sv
// Register-port bundle between the I2C target (master side) and a register file (slave side).
interface i2c_target_if;
    import i2c_target_pkg::*;

    logic [SUB_W-1:0] reg_addr;
    logic [SUB_W-1:0] reg_wdata;
    logic             reg_we;
    logic             reg_re;
    logic [SUB_W-1:0] reg_rdata;
    logic             busy;
    logic             rx_nack;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re, busy, rx_nack,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re, busy, rx_nack,
        output reg_rdata
    );

endinterface

// File: rtl/i2c_target_line_sync.sv
// Bus line conditioner: 2-FF synchroniser, optional 3-sample majority filter
// (enabled by I2C_TGT_GLITCH_FILTER_EN), and rise/fall edge detection.
// All flops reset to 1 so an idle (pulled-up) bus produces no edge after reset.
module i2c_target_line_sync (
    input  logic clk_50,
    input  logic rst_n,
    input  logic line_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       cur;

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] hist_q;
    logic       filt_q;

    // Majority of the last three synchronised samples; a 1-cycle pulse never wins.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 3'b111;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[1:0], sync_q[1]};
            filt_q <= (hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) | (hist_q[0] & hist_q[2]);
        end
    end

    assign cur = filt_q;
`else
    assign cur = sync_q[1];
`endif

    // Metastability synchroniser and previous-level register for edge detection.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_in};
            prev_q <= cur;
        end
    end

    assign lvl  = cur;
    assign rise = cur & ~prev_q;
    assign fall = ~cur & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address + 8-bit sub-address, auto-incrementing register pointer,
// open-drain SDA (0 or Z), no clock stretching.
// Optional build macro: I2C_TGT_GLITCH_FILTER_EN (majority filter on SCL/SDA).
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEV_ADDR    = 7'h3C,
    parameter int                PTR_AUTOINC = 1
) (
    input  logic         clk_50,
    input  logic         rst_n,
    input  logic         SCL,
    inout  wire          SDA,
    i2c_target_if.master rif
);

    localparam logic [SUB_W-1:0] PTR_STEP = (PTR_AUTOINC != 0) ? SUB_W'(1) : '0;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    tgt_state_e       state_q, state_n;
    logic [3:0]       bit_cnt_q, bit_cnt_n;
    logic [SUB_W-1:0] rx_q, rx_n;
    logic [SUB_W-1:0] tx_q, tx_n;
    logic [SUB_W-1:0] addr_q, addr_n;
    logic [SUB_W-1:0] wdata_q, wdata_n;
    logic             sda_oe_q, sda_oe_n;
    logic             we_q, we_n;
    logic             re_q, re_n;
    logic             busy_q, busy_n;
    logic             nack_q, nack_n;
    logic             rd_vld_q;

    i2c_target_line_sync u_scl (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .line_in(SCL),
        .lvl    (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_target_line_sync u_sda (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .line_in(SDA),
        .lvl    (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    // Both lines share the same lag, so SCL level is aligned with SDA edges.
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    assign SDA           = sda_oe_q ? 1'b0 : 1'bz;
    assign rif.reg_addr  = addr_q;
    assign rif.reg_wdata = wdata_q;
    assign rif.reg_we    = we_q;
    assign rif.reg_re    = re_q;
    assign rif.busy      = busy_q;
    assign rif.rx_nack   = nack_q;

    // State and datapath registers; reset releases SDA asynchronously.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sda_oe_q  <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
            nack_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            rx_q      <= rx_n;
            tx_q      <= tx_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            sda_oe_q  <= sda_oe_n;
            we_q      <= we_n;
            re_q      <= re_n;
            busy_q    <= busy_n;
            nack_q    <= nack_n;
            rd_vld_q  <= re_q;
        end
    end

    // Next-state and output logic; START/STOP override any bit event in the same cycle.
    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        rx_n      = rx_q;
        tx_n      = tx_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        sda_oe_n  = sda_oe_q;
        busy_n    = busy_q;
        we_n      = 1'b0;
        re_n      = 1'b0;
        nack_n    = 1'b0;

        // Read data arrives one cycle after the strobe, long before the next SCL fall.
        if (rd_vld_q) tx_n = rif.reg_rdata;

        if (stop_det) begin
            state_n   = ST_IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = '0;
        end else if (start_det) begin
            state_n   = ST_ADDR;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = '0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != ACK_SLOT) begin
                        rx_n      = {rx_q[SUB_W-2:0], sda_lvl};
                        bit_cnt_n = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == ACK_SLOT) begin
                        sda_oe_n = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (rx_q[SUB_W-1:1] == DEV_ADDR) begin
                                busy_n  = 1'b1;
                                re_n    = rx_q[0];
                                state_n = ST_ACK_A;
                            end else begin
                                sda_oe_n  = 1'b0;
                                bit_cnt_n = '0;
                                state_n   = ST_WAIT_P;
                            end
                        end else if (state_q == ST_SUB) begin
                            addr_n  = rx_q;
                            state_n = ST_ACK_S;
                        end else begin
                            wdata_n = rx_q;
                            we_n    = 1'b1;
                            state_n = ST_ACK_W;
                        end
                    end
                end
                ST_ACK_A, ST_ACK_S, ST_ACK_W: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        sda_oe_n  = 1'b0;
                        if (state_q == ST_ACK_A && rx_q[0]) begin
                            sda_oe_n = ~tx_q[SUB_W-1];
                            state_n  = ST_RDATA;
                        end else if (state_q == ST_ACK_A) begin
                            state_n = ST_SUB;
                        end else begin
                            if (state_q == ST_ACK_W) addr_n = addr_q + PTR_STEP;
                            state_n = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    // bit_cnt counts bits already clocked out to the initiator.
                    if (scl_rise && bit_cnt_q != ACK_SLOT) begin
                        bit_cnt_n = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == '0) begin
                            sda_oe_n = ~tx_q[SUB_W-1];
                        end else if (bit_cnt_q == ACK_SLOT) begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_RACK;
                        end else begin
                            tx_n     = {tx_q[SUB_W-2:0], 1'b0};
                            sda_oe_n = ~tx_q[SUB_W-2];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        bit_cnt_n = '0;
                        if (sda_lvl == ACK) begin
                            addr_n  = addr_q + PTR_STEP;
                            re_n    = 1'b1;
                            state_n = ST_RDATA;
                        end else begin
                            nack_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = ST_WAIT_P;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C initiator plus register-file responder around i2c_target, checked
// against a transaction-level model (pointer, memory image, expected strobe queues).
module tb_i2c_target;

    localparam logic [6:0] DEV = 7'h3C;
    localparam int         H   = 16;   // clk_50 cycles per SCL half period
    localparam int         Q   = 8;    // quarter period

    logic clk_50  = 1'b0;
    logic rst_n   = 1'b0;
    logic scl     = 1'b1;
    logic sda_low = 1'b0;
    bit   glitch  = 1'b0;
    wire  sda;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_if rif ();

    i2c_target #(.DEV_ADDR(DEV), .PTR_AUTOINC(1)) dut (
        .clk_50(clk_50),
        .rst_n (rst_n),
        .SCL   (scl),
        .SDA   (sda),
        .rif   (rif.master)
    );

    always #10 clk_50 = ~clk_50;

    int n_chk = 0, n_fail = 0;
    int we_cnt = 0, re_cnt = 0, nack_cnt = 0;
    logic [7:0]  last_we_addr = '0;
    logic [7:0]  mmem [256];     // model memory image
    logic [7:0]  tbmem [256];    // responder memory, updated only by DUT writes
    logic [7:0]  mptr = '0;      // model register pointer
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  wbuf [$];
    logic [7:0]  rd_log [$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    // Register-file responder and strobe checker, evaluated every cycle away from posedge.
    initial begin
        logic [15:0] e;
        logic [7:0]  ea;
        rif.reg_rdata = '0;
        forever begin
            @(negedge clk_50);
            if (rif.reg_we && rif.reg_re) chk("we_re_same_cycle", 1, 0);
            if (rif.reg_we) begin
                we_cnt++;
                last_we_addr = rif.reg_addr;
                if (exp_wr.size() == 0) chk("we_unexpected", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    chk("we_addr", rif.reg_addr, e[15:8]);
                    chk("we_data", rif.reg_wdata, e[7:0]);
                end
                tbmem[rif.reg_addr] = rif.reg_wdata;
            end
            if (rif.reg_re) begin
                re_cnt++;
                if (exp_rd.size() == 0) chk("re_unexpected", 1, 0);
                else begin
                    ea = exp_rd.pop_front();
                    chk("re_addr", rif.reg_addr, ea);
                end
                rif.reg_rdata = tbmem[rif.reg_addr];
            end
            if (rif.rx_nack) nack_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    // One SCL clock with SDA driven to b; returns the bus level sampled mid-high.
    task automatic send_bit(input logic b, output logic s);
        tick(Q);
        sda_low = ~b;
        tick(Q);
        scl = 1'b1;
        if (glitch) begin
            tick(3); scl = 1'b0; tick(1); scl = 1'b1; tick(Q - 4);
        end else tick(Q);
        s = (sda === 1'b0) ? 1'b0 : 1'b1;
        tick(Q);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], s);
            if (b[i]) chk("sda_free_during_tx", s, 1);
        end
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
    endtask

    task automatic i2c_start();
        tick(Q);
        sda_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(H);
        sda_low = 1'b1;
        tick(H);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q);
        sda_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(H);
        sda_low = 1'b0;
        tick(H);
    endtask

    // Write transaction: address, sub-address, then the bytes in wbuf.
    task automatic xfer_write(input logic [6:0] a, input logic [7:0] sub);
        logic ack;
        bit   ok;
        ok = (a == DEV);
        i2c_start();
        send_byte({a, 1'b0}, ack);
        chk("addr_ack", ack, ok);
        chk("busy_after_addr", rif.busy, ok);
        send_byte(sub, ack);
        chk("sub_ack", ack, ok);
        if (ok) mptr = sub;
        foreach (wbuf[i]) begin
            if (ok) begin
                exp_wr.push_back({mptr, wbuf[i]});
                mmem[mptr] = wbuf[i];
            end
            send_byte(wbuf[i], ack);
            chk("data_ack", ack, ok);
            if (ok) mptr++;
        end
        i2c_stop();
        chk("busy_after_stop", rif.busy, 0);
    endtask

    // Read transaction of n bytes, optionally preceded by a sub-address write and Sr.
    task automatic xfer_read(input logic [6:0] a, input bit set_sub, input logic [7:0] sub, input int n);
        logic       ack, s;
        logic [7:0] b;
        bit         ok;
        int         n0;
        ok = (a == DEV);
        rd_log.delete();
        if (set_sub) begin
            i2c_start();
            send_byte({a, 1'b0}, ack);
            chk("waddr_ack", ack, ok);
            send_byte(sub, ack);
            chk("sub_ack", ack, ok);
            if (ok) mptr = sub;
        end
        i2c_start();
        if (ok) exp_rd.push_back(mptr);
        send_byte({a, 1'b1}, ack);
        chk("raddr_ack", ack, ok);
        chk("busy_after_raddr", rif.busy, ok);
        if (!ok) begin
            i2c_stop();
            chk("busy_after_stop", rif.busy, 0);
            return;
        end
        n0 = nack_cnt;
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            rd_log.push_back(b);
            chk("rdata", b, mmem[mptr]);
            if (i < n - 1) begin
                mptr++;
                exp_rd.push_back(mptr);
                send_bit(1'b0, s);
            end else send_bit(1'b1, s);
        end
        i2c_stop();
        chk("rx_nack_pulses", nack_cnt - n0, 1);
        chk("busy_after_stop", rif.busy, 0);
    endtask

    initial begin
        logic       ack, s;
        logic [6:0] ra;
        logic [7:0] rs;
        int         w0, r0, kind, n;

        for (int i = 0; i < 256; i++) begin
            mmem[i]  = 8'($urandom);
            tbmem[i] = mmem[i];
        end

        // Reset state
        tick(4);
        chk("rst_sda_released", (sda === 1'b0) ? 0 : 1, 1);
        chk("rst_reg_addr", rif.reg_addr, 0);
        chk("rst_reg_wdata", rif.reg_wdata, 0);
        chk("rst_reg_we", rif.reg_we, 0);
        chk("rst_reg_re", rif.reg_re, 0);
        chk("rst_busy", rif.busy, 0);
        chk("rst_rx_nack", rif.rx_nack, 0);
        rst_n = 1'b1;
        tick(H);

        // 1: two-byte write at 0x10
        w0 = we_cnt;
        wbuf = '{8'hA5, 8'h5A};
        xfer_write(DEV, 8'h10);
        chk("t1_we_count", we_cnt - w0, 2);
        chk("t1_last_we_addr", last_we_addr, 8'h11);
        chk("t1_model_ptr", mptr, 8'h12);

        // 2: sub 0x20, Sr, read two bytes
        mmem[8'h20] = 8'h11; tbmem[8'h20] = 8'h11;
        mmem[8'h21] = 8'h22; tbmem[8'h21] = 8'h22;
        r0 = re_cnt;
        xfer_read(DEV, 1'b1, 8'h20, 2);
        chk("t2_byte0", rd_log[0], 8'h11);
        chk("t2_byte1", rd_log[1], 8'h22);
        chk("t2_re_count", re_cnt - r0, 2);

        // 3: wrong address
        w0 = we_cnt;
        wbuf = '{8'h77};
        xfer_write(7'h3D, 8'h05);
        chk("t3_no_we", we_cnt - w0, 0);

        // 4: pointer wrap
        wbuf = '{8'h01, 8'h02, 8'h03};
        xfer_write(DEV, 8'hFF);
        chk("t4_last_we_addr", last_we_addr, 8'h01);
        chk("t4_model_ptr", mptr, 8'h02);

        // 5: STOP after 4 data bits, then a normal transfer
        w0 = we_cnt;
        i2c_start();
        send_byte({DEV, 1'b0}, ack);
        chk("t5_addr_ack", ack, 1);
        send_byte(8'h40, ack);
        chk("t5_sub_ack", ack, 1);
        mptr = 8'h40;
        for (int i = 0; i < 4; i++) send_bit(i[0], s);
        i2c_stop();
        chk("t5_no_we", we_cnt - w0, 0);
        chk("t5_busy", rif.busy, 0);
        wbuf = '{8'hC3};
        xfer_write(DEV, 8'h41);

        // 6: reset while the target drives ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : DEV[i-1], s);
        tick(Q);
        sda_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        chk("t6_ack_driven", (sda === 1'b0) ? 1 : 0, 1);
        chk("t6_busy_before", rif.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_sda_released", (sda === 1'b0) ? 0 : 1, 1);
        chk("t6_reg_addr", rif.reg_addr, 0);
        chk("t6_busy", rif.busy, 0);
        chk("t6_we_re", {rif.reg_we, rif.reg_re, rif.rx_nack}, 0);
        mptr = '0;
        tick(4);
        rst_n = 1'b1;
        tick(H);

`ifdef I2C_TGT_GLITCH_FILTER_EN
        glitch = 1'b1;
        wbuf = '{8'h96};
        xfer_write(DEV, 8'h80);
        glitch = 1'b0;
`endif

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            ra   = DEV;
            if ($urandom_range(0, 4) == 0) begin
                ra = 7'($urandom_range(0, 127));
                if (ra == DEV) ra = DEV ^ 7'h01;
            end
            rs = 8'($urandom);
            if (kind == 0) begin
                wbuf.delete();
                for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
                xfer_write(ra, rs);
            end else xfer_read(ra, kind == 1, rs, n);
        end

        tick(H);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
